// File: rtl/x_arb_pkg.sv
// rtl/x_arb_pkg.sv - shared FSM state type and one-hot decode helper for the round-robin arbiter
package x_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Sized for the widest supported arbiter; callers zero-extend and truncate.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsb_priority_arb.sv
// rtl/lsb_priority_arb.sv - combinational lowest-index-wins priority selector
module lsb_priority_arb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] gnt_o
);

  // Two's-complement isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/x_rr_arbiter_hs.sv
// rtl/x_rr_arbiter_hs.sv - masked round-robin arbiter with registered grant and ack handshake
import x_arb_pkg::*;

module x_rr_arbiter_hs #(
  parameter int ROWS    = 8,
  parameter int X_WIDTH = $clog2(ROWS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               refresh_i,
  input  logic               fixed_pri_i,
  input  logic [ROWS-1:0]    req_i,
  input  logic               ack_i,
  output logic [ROWS-1:0]    gnt_o,
  output logic               gnt_valid_o,
  output logic [X_WIDTH-1:0] xadd_o,
  output logic               grp_release_o
);

  arb_state_e         state_q;
  logic [ROWS-1:0]    mask_q;
  logic [ROWS-1:0]    gnt_q;
  logic [X_WIDTH-1:0] xadd_q;
  logic               gnt_valid_q;
  logic               grp_release_q;

  logic [ROWS-1:0]    mask_req;
  logic [ROWS-1:0]    masked_gnt;
  logic [ROWS-1:0]    raw_gnt;
  logic [ROWS-1:0]    cand;
  logic [X_WIDTH-1:0] cand_idx;
  logic [X_WIDTH:0]   shamt;
  logic [ROWS-1:0]    mask_d;
  logic               unmasked;
  logic               issue;

  assign mask_req = req_i & mask_q;

  lsb_priority_arb #(.WIDTH(ROWS)) u_masked_arb (
    .req_i (mask_req),
    .gnt_o (masked_gnt)
  );

  lsb_priority_arb #(.WIDTH(ROWS)) u_raw_arb (
    .req_i (req_i),
    .gnt_o (raw_gnt)
  );

  always_comb begin
    unmasked = (mask_req == '0);
    cand     = (fixed_pri_i || unmasked) ? raw_gnt : masked_gnt;
    cand_idx = X_WIDTH'(onehot_to_idx(64'(cand)));
    // Extra bit lets the shift reach ROWS, emptying the mask after the top row.
    shamt    = {1'b0, cand_idx} + (X_WIDTH+1)'(1);
    mask_d   = {ROWS{1'b1}} << shamt;
    issue    = enable_i && (req_i != '0) && ((state_q == IDLE) || ack_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      mask_q        <= '1;
      gnt_q         <= '0;
      xadd_q        <= '0;
      gnt_valid_q   <= 1'b0;
      grp_release_q <= 1'b0;
    end else begin
      grp_release_q <= 1'b0;
      if (issue) begin
        state_q       <= GRANT;
        gnt_q         <= cand;
        xadd_q        <= cand_idx;
        gnt_valid_q   <= 1'b1;
        grp_release_q <= !fixed_pri_i && unmasked;
        if (!fixed_pri_i) mask_q <= mask_d;
      end else if ((state_q == GRANT) && ack_i) begin
        state_q     <= IDLE;
        gnt_q       <= '0;
        xadd_q      <= '0;
        gnt_valid_q <= 1'b0;
      end
      if (refresh_i) mask_q <= '1;
    end
  end

  assign gnt_o         = gnt_q;
  assign xadd_o        = xadd_q;
  assign gnt_valid_o   = gnt_valid_q;
  assign grp_release_o = grp_release_q;

endmodule

// File: tb/tb_x_rr_arbiter_hs.sv
// tb/tb_x_rr_arbiter_hs.sv - directed and random checks of x_rr_arbiter_hs against a pointer-based model
module tb_x_rr_arbiter_hs;

  localparam int ROWS    = 8;
  localparam int X_WIDTH = 3;

  logic               clk = 1'b0;
  logic               reset_i = 1'b0;
  logic               enable_i = 1'b0;
  logic               refresh_i = 1'b0;
  logic               fixed_pri_i = 1'b0;
  logic [ROWS-1:0]    req_i = '0;
  logic               ack_i = 1'b0;
  logic [ROWS-1:0]    gnt_o;
  logic               gnt_valid_o;
  logic [X_WIDTH-1:0] xadd_o;
  logic               grp_release_o;

  int vectors = 0;
  int miscompares = 0;

  // Model: pointer to the last round-robin winner (-1 = fresh pass), busy flag, granted row.
  int m_last = -1;
  bit m_busy = 0;
  int m_idx  = 0;
  bit m_rel  = 0;

  x_rr_arbiter_hs #(.ROWS(ROWS), .X_WIDTH(X_WIDTH)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .refresh_i     (refresh_i),
    .fixed_pri_i   (fixed_pri_i),
    .req_i         (req_i),
    .ack_i         (ack_i),
    .gnt_o         (gnt_o),
    .gnt_valid_o   (gnt_valid_o),
    .xadd_o        (xadd_o),
    .grp_release_o (grp_release_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [ROWS-1:0] r);
    for (int i = 0; i < ROWS; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int  pick;
    bit  wrap;
    if (reset_i) begin
      m_busy = 0; m_idx = 0; m_rel = 0; m_last = -1;
      return;
    end
    m_rel = 0;
    if (enable_i && req_i != 0 && (!m_busy || ack_i)) begin
      wrap = 0;
      pick = -1;
      if (fixed_pri_i) begin
        pick = lowest(req_i);
      end else begin
        for (int i = m_last + 1; i < ROWS; i++) begin
          if (req_i[i] && pick < 0) pick = i;
        end
        if (pick < 0) begin
          pick = lowest(req_i);
          wrap = 1;
        end
        m_last = pick;
      end
      m_busy = 1;
      m_idx  = pick;
      m_rel  = wrap;
    end else if (m_busy && ack_i) begin
      m_busy = 0;
      m_idx  = 0;
    end
    if (refresh_i) m_last = -1;
  endtask

  task automatic tick();
    logic [ROWS-1:0] exp_gnt;
    model_step();
    @(posedge clk);
    #1;
    exp_gnt = m_busy ? ROWS'(1) << m_idx : '0;
    check("gnt", gnt_o, exp_gnt);
    check("valid", gnt_valid_o, m_busy);
    check("xadd", xadd_o, m_busy ? m_idx : 0);
    check("release", grp_release_o, m_rel);
  endtask

  initial begin
    // Reset
    reset_i = 1; tick();
    check("rst_gnt", gnt_o, 0);
    check("rst_valid", gnt_valid_o, 0);
    check("rst_rel", grp_release_o, 0);
    reset_i = 0;

    // First grant, no bubble on ack, wrap release
    req_i = 8'h12; enable_i = 1; tick();
    check("g1_gnt", gnt_o, 8'h02);
    check("g1_xadd", xadd_o, 1);
    check("g1_rel", grp_release_o, 0);
    ack_i = 1; tick();
    check("g2_gnt", gnt_o, 8'h10);
    check("g2_xadd", xadd_o, 4);
    check("g2_valid", gnt_valid_o, 1);
    tick();
    check("wrap_gnt", gnt_o, 8'h02);
    check("wrap_rel", grp_release_o, 1);
    ack_i = 0; tick();
    check("wrap_pulse_end", grp_release_o, 0);

    // Grant held with request dropped and no ack
    req_i = 8'h80; ack_i = 1; tick();
    check("g80", gnt_o, 8'h80);
    req_i = 8'h00; ack_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold80", gnt_o, 8'h80);
    end
    ack_i = 1; tick();
    check("drop_valid", gnt_valid_o, 0);

    // Refresh after granting row 5
    req_i = 8'h20; ack_i = 0; tick();
    check("g5_xadd", xadd_o, 5);
    req_i = 8'h00; ack_i = 1; refresh_i = 1; tick();
    refresh_i = 0; ack_i = 0; req_i = 8'h09; tick();
    check("ref_xadd", xadd_o, 0);
    check("ref_rel", grp_release_o, 0);

    // Fixed priority
    fixed_pri_i = 1; req_i = 8'h0C; ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fix_gnt", gnt_o, 8'h04);
      check("fix_rel", grp_release_o, 0);
    end
    fixed_pri_i = 0; req_i = 8'h00; tick();

    // Reset mid-grant
    req_i = 8'h40; ack_i = 0; tick();
    check("g6_gnt", gnt_o, 8'h40);
    reset_i = 1; tick();
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_xadd", xadd_o, 0);
    check("mid_rst_valid", gnt_valid_o, 0);
    reset_i = 0; req_i = 8'h48; tick();
    check("post_rst_gnt", gnt_o, 8'h08);
    check("post_rst_rel", grp_release_o, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      req_i       = ($urandom_range(0, 3) == 0) ? '0 : ROWS'($urandom);
      enable_i    = ($urandom_range(0, 9) < 8);
      ack_i       = $urandom_range(0, 1);
      fixed_pri_i = ($urandom_range(0, 9) == 0);
      refresh_i   = ($urandom_range(0, 19) == 0);
      reset_i     = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/x_rr_arbiter_hs.md
X_RR_ARBITER_HS -- requirements
Module: x_rr_arbiter_hs

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning number of requesters; legal range 2..64.
REQ-002 SHALL have parameter X_WIDTH, default $clog2(ROWS), meaning width of the encoded grant index.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1 bit: permits issuing new grants.
REQ-006 SHALL have port refresh_i, input, 1 bit: reloads the round-robin mask to all-ones.
REQ-007 SHALL have port fixed_pri_i, input, 1 bit: 1 selects fixed lowest-index priority and bypasses the mask.
REQ-008 SHALL have port req_i, input, ROWS bits: level request per row.
REQ-009 SHALL have port ack_i, input, 1 bit: consumer accepts the current grant.
REQ-010 SHALL have port gnt_o, output, ROWS bits: registered one-hot grant.
REQ-011 SHALL have port gnt_valid_o, output, 1 bit: gnt_o and xadd_o are valid.
REQ-012 SHALL have port xadd_o, output, X_WIDTH bits: index of the set bit of gnt_o, 0 when no grant.
REQ-013 SHALL have port grp_release_o, output, 1 bit: one-cycle pulse marking the first grant of a new round-robin pass.

Function
REQ-014 SHALL implement FSM states IDLE and GRANT; reset state is IDLE.
REQ-015 SHALL compute mask_req = req_i AND mask; candidate = lowest set bit of mask_req when nonzero, else lowest set bit of req_i.
REQ-016 SHALL, when fixed_pri_i=1, select the candidate as the lowest set bit of req_i and leave the mask unchanged.
REQ-017 SHALL arbitrate in IDLE when enable_i=1 and req_i is nonzero; on the next edge gnt_o = candidate, gnt_valid_o=1, xadd_o = index, and the state is GRANT (1-cycle latency).
REQ-018 SHALL set the mask at the grant edge to all-ones shifted left by (index+1), which gives all-zeros for index ROWS-1.
REQ-019 SHALL hold gnt_o, xadd_o and gnt_valid_o stable in GRANT until ack_i=1, even if the granted req_i bit drops or enable_i falls.
REQ-020 SHALL, on ack_i=1 in GRANT with enable_i=1 and req_i nonzero, issue the next grant on the following edge with no bubble; otherwise it SHALL clear gnt_o, clear xadd_o and gnt_valid_o, and return to IDLE.
REQ-021 SHALL ignore ack_i in IDLE.
REQ-022 SHALL assert grp_release_o for exactly one cycle, coincident with the registered grant, when that grant came from the unmasked path (mask_req=0) and fixed_pri_i=0.
REQ-023 SHALL, on refresh_i=1, load the mask to all-ones in any state without affecting an outstanding grant; when refresh_i coincides with a grant edge, refresh wins for the mask.
REQ-024 SHALL keep grp_release_o at 0 for the first grant after reset or refresh, because mask_req is then nonzero.
REQ-025 SHALL hold state, mask and outputs when enable_i=0 in IDLE.

Reset
REQ-026 SHALL, on reset_i=1 at a clock edge, set state to IDLE, mask to all-ones, and gnt_o, xadd_o, gnt_valid_o and grp_release_o to 0; reset overrides all other inputs, including mid-grant.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, GRANT) and a onehot-to-index function in shared package x_arb_pkg.
REQ-028 SHALL instantiate a parametrised lowest-index priority arbiter sub-module lsb_priority_arb (parameter WIDTH) twice: once on the masked requests and once on the raw requests.
REQ-029 SHALL register every output; there SHALL be no combinational path from req_i or ack_i to any output.

Verification (ROWS=8)
REQ-030 SHALL check: reset, then req_i=8'h12, enable_i=1 -> next cycle gnt_o=8'h02, xadd_o=1, gnt_valid_o=1, grp_release_o=0.
REQ-031 SHALL check: with the 8'h02 grant held, ack_i=1 while req_i=8'h12 -> next cycle gnt_o=8'h10, xadd_o=4, no bubble; then ack_i=1 -> gnt_o=8'h02 with grp_release_o=1 for 1 cycle (wrap).
REQ-032 SHALL check: grant 8'h80 held, req_i dropped to 0 and ack_i=0 for 5 cycles -> gnt_o stays 8'h80; then ack_i=1 -> gnt_valid_o=0, state IDLE.
REQ-033 SHALL check: mask after granting index 5, then refresh_i=1 and req_i=8'h09 -> next grant xadd_o=0, grp_release_o=0.
REQ-034 SHALL check: fixed_pri_i=1, req_i=8'h0C with repeated acks -> every grant is 8'h04 and grp_release_o stays 0.
REQ-035 SHALL check: reset_i=1 asserted while in GRANT -> next cycle all outputs 0, mask all-ones, and the first subsequent grant is the lowest requesting index.
